alu_op_decoder: RTL and testbench
=================================

// Module: alu_op_decoder
// PURPOSE
// - Registered decode stage that drives the ALU: turns a 32-bit MIPS instruction into ALUOp, shamt, operand selects and control flags.
// - Sits between instruction fetch (behind the I-cache) and the execute stage; one-entry output register with valid/ready on both sides.
// - Memory stalls are absorbed by ready back-pressure; a taken branch squashes the held op with flush.
// PARAMETERS
// - bit_size  32  datapath width; width of imm_ext.
// PORTS
// - clk        in   1         rising-edge clock (single clock domain)
// - rst        in   1         asynchronous, active-low reset
// - in_valid   in   1         instr is valid this cycle
// - in_ready   out  1         decoder accepts instr this cycle
// - instr      in   32        MIPS instruction word
// - flush      in   1         squash held op and any same-cycle input
// - out_valid  out  1         decoded bundle valid
// - out_ready  in   1         execute stage consumes bundle
// - ALUOp      out  4         0 none,1 add,2 sub,3 and,4 or,5 xor,6 nor,7 slt,8 sll,9 srl,10 beq,11 bne
// - shamt      out  5         instr[10:6] for sll/srl, else 0
// - src2_imm   out  1         1: ALU src2 = imm_ext, 0: rt register
// - imm_ext    out  bit_size  sign- or zero-extended imm; lui: {imm,16'b0}
// - src1_zero  out  1         force ALU src1 = 0 (lui only)
// - reg_write  out  1         writes register file
// - wr_dst     out  5         destination: rd (R-type), rt (I-type), 31 (jal), else 0
// - mem_read / mem_write  out  1 each   lw / sw
// - branch / jump / jump_reg  out  1 each   beq|bne / j|jal / jr
// - illegal    out  1         sticky: an unsupported instruction was accepted
// BEHAVIOUR
// - Reset (rst=0, async): out_valid=0, every payload output=0, illegal=0; in_ready=1 after release.
// - in_ready = !out_valid || out_ready (combinational); accept = in_valid && in_ready && !flush.
// - Latency 1: an instr accepted at edge N is presented with out_valid=1 after edge N.
// - Hold: out_valid && !out_ready -> whole bundle stable, no accept.
// - Simultaneous consume+accept: new bundle replaces old with no bubble (full throughput).
// - out_valid && out_ready && !accept -> out_valid=0 next cycle; payload may keep last value.
// - flush=1: out_valid=0 next cycle, input dropped regardless of in_valid/out_ready; flush beats accept.
// - R-type (op 0), keyed by funct: 20/21->1; 22/23->2; 24->3; 25->4; 26->5; 27->6; 2A->7 (all reg_write, dst rd);
//   00->8, 02->9 (reg_write, dst rd, shamt); 08 jr->ALUOp 0, jump_reg=1. instr 0 (sll $0) = nop.
// - I-type, keyed by opcode: 08/09->1 sign; 0A->7 sign; 0C->3, 0D->4, 0E->5 zero-ext; 0F lui->1, src1_zero;
//   all src2_imm=1, reg_write=1, dst rt. 23 lw->1 sign, mem_read, reg_write. 2B sw->1 sign, mem_write.
// - 04 beq->10, 05 bne->11: branch=1, src2_imm=0, imm_ext sign-extended. 02 j / 03 jal: ALUOp 0, jump=1; jal reg_write, dst 31.
// - Any other opcode/funct: bundle all-zero (nop, out_valid still 1), illegal set; cleared only by reset.
// - wr_dst=0 forces reg_write=0.
// - Reset mid-operation: held bundle discarded immediately, outputs return to reset values.
// TESTING
// - add $3,$1,$2 (0x00221820), out_ready=1 -> next cycle ALUOp=1, wr_dst=3, reg_write=1, src2_imm=0.
// - andi $5,$4,0x8001 -> ALUOp=3, imm_ext=0x00008001, src2_imm=1; addi same imm -> ALUOp=1, imm_ext=0xFFFF8001.
// - sll $2,$2,4, out_ready=0 for 3 cycles -> ALUOp=8, shamt=4 held, in_ready=0; consumed on 4th cycle.
// - back-to-back beq/bne, out_ready=1 -> ALUOp 10 then 11 on consecutive cycles, branch=1, no bubble.
// - op held, flush=1 with in_valid=1 -> out_valid=0 next cycle, input not decoded.
// - opcode 0x3F -> out_valid=1, ALUOp=0, illegal=1 stays set; rst low mid-hold -> all outputs 0 at once.

Source files
------------

// File: rtl/alu_op_decoder_if.sv
// alu_op_decoder_if: fetch-side handshake and decoded ALU bundle for the decode stage
interface alu_op_decoder_if #(parameter int bit_size = 32);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         instr;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [3:0]          ALUOp;
  logic [4:0]          shamt;
  logic                src2_imm;
  logic [bit_size-1:0] imm_ext;
  logic                src1_zero;
  logic                reg_write;
  logic [4:0]          wr_dst;
  logic                mem_read;
  logic                mem_write;
  logic                branch;
  logic                jump;
  logic                jump_reg;
  logic                illegal;
  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, ALUOp, shamt, src2_imm, imm_ext, src1_zero,
           reg_write, wr_dst, mem_read, mem_write, branch, jump, jump_reg, illegal
  );
  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, ALUOp, shamt, src2_imm, imm_ext, src1_zero,
           reg_write, wr_dst, mem_read, mem_write, branch, jump, jump_reg, illegal
  );
endinterface

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: registered MIPS decode stage with a one-entry valid/ready output buffer
module alu_op_decoder #(parameter int bit_size = 32) (
  input logic clk,
  input logic rst,
  alu_op_decoder_if.slave bus
);
  typedef struct packed {
    logic [3:0]          alu_op;
    logic [4:0]          shamt;
    logic                src2_imm;
    logic [bit_size-1:0] imm_ext;
    logic                src1_zero;
    logic                reg_write;
    logic [4:0]          wr_dst;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                jump;
    logic                jump_reg;
  } bundle_t;
  bundle_t             dec, bundle_d, bundle_q;
  logic                ill, accept, valid_d, valid_q, illegal_d, illegal_q;
  logic [5:0]          op, fn;
  logic [4:0]          rt, rd;
  logic [15:0]         imm;
  logic [bit_size-1:0] sx, zx;
  assign op  = bus.instr[31:26];
  assign fn  = bus.instr[5:0];
  assign rt  = bus.instr[20:16];
  assign rd  = bus.instr[15:11];
  assign imm = bus.instr[15:0];
  assign sx  = {{(bit_size-16){imm[15]}}, imm};
  assign zx  = {{(bit_size-16){1'b0}}, imm};
  always_comb begin
    dec = '0;
    ill = 1'b0;
    case (op)
      6'h00: begin
        dec.reg_write = 1'b1;
        dec.wr_dst    = rd;
        case (fn)
          6'h20, 6'h21: dec.alu_op = 4'd1;
          6'h22, 6'h23: dec.alu_op = 4'd2;
          6'h24:        dec.alu_op = 4'd3;
          6'h25:        dec.alu_op = 4'd4;
          6'h26:        dec.alu_op = 4'd5;
          6'h27:        dec.alu_op = 4'd6;
          6'h2a:        dec.alu_op = 4'd7;
          6'h00, 6'h02: begin
            dec.alu_op = fn[1] ? 4'd9 : 4'd8;
            dec.shamt  = bus.instr[10:6];
          end
          6'h08: begin
            dec.reg_write = 1'b0;
            dec.wr_dst    = 5'd0;
            dec.jump_reg  = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23: begin
        dec.src2_imm  = 1'b1;
        dec.reg_write = 1'b1;
        dec.wr_dst    = rt;
        dec.alu_op    = op == 6'h0a ? 4'd7 : op == 6'h0c ? 4'd3 : op == 6'h0d ? 4'd4 :
                        op == 6'h0e ? 4'd5 : 4'd1;
        dec.imm_ext   = op == 6'h0f ? zx << 16 : op inside {6'h0c, 6'h0d, 6'h0e} ? zx : sx;
        dec.src1_zero = op == 6'h0f;
        dec.mem_read  = op == 6'h23;
      end
      6'h2b: begin
        dec.alu_op    = 4'd1;
        dec.src2_imm  = 1'b1;
        dec.imm_ext   = sx;
        dec.mem_write = 1'b1;
      end
      6'h04, 6'h05: begin
        dec.alu_op  = op[0] ? 4'd11 : 4'd10;
        dec.branch  = 1'b1;
        dec.imm_ext = sx;
      end
      6'h02, 6'h03: begin
        dec.jump      = 1'b1;
        dec.reg_write = op[0];
        dec.wr_dst    = op[0] ? 5'd31 : 5'd0;
      end
      default: ill = 1'b1;
    endcase
    if (ill) dec = '0;
    dec.reg_write = dec.reg_write && |dec.wr_dst;
  end
  // flush wins over both a pending accept and a held bundle
  always_comb begin
    bus.in_ready = !valid_q || bus.out_ready;
    accept       = bus.in_valid && bus.in_ready && !bus.flush;
    valid_d      = !bus.flush && (accept || (valid_q && !bus.out_ready));
    bundle_d     = accept ? dec : bundle_q;
    illegal_d    = illegal_q || (accept && ill);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      bundle_q  <= '0;
    end else begin
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      bundle_q  <= bundle_d;
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.illegal   = illegal_q;
  assign bus.ALUOp     = bundle_q.alu_op;
  assign bus.shamt     = bundle_q.shamt;
  assign bus.src2_imm  = bundle_q.src2_imm;
  assign bus.imm_ext   = bundle_q.imm_ext;
  assign bus.src1_zero = bundle_q.src1_zero;
  assign bus.reg_write = bundle_q.reg_write;
  assign bus.wr_dst    = bundle_q.wr_dst;
  assign bus.mem_read  = bundle_q.mem_read;
  assign bus.mem_write = bundle_q.mem_write;
  assign bus.branch    = bundle_q.branch;
  assign bus.jump      = bundle_q.jump;
  assign bus.jump_reg  = bundle_q.jump_reg;
endmodule

// File: tb/tb_alu_op_decoder.sv
// tb_alu_op_decoder: directed plus random checks of the decode stage against a table-style reference model
module tb_alu_op_decoder;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic        exp_v, exp_il;
  logic [54:0] exp_b, obs;
  always #5 clk = ~clk;
  alu_op_decoder_if bus ();
  alu_op_decoder dut (.clk(clk), .rst(rst), .bus(bus));
  assign obs = {bus.ALUOp, bus.shamt, bus.src2_imm, bus.imm_ext, bus.src1_zero, bus.reg_write,
                bus.wr_dst, bus.mem_read, bus.mem_write, bus.branch, bus.jump, bus.jump_reg};
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask
  // reference decode written from the opcode/funct tables as plain arithmetic
  task automatic ref_dec(input logic [31:0] i, output logic [54:0] b, output logic il);
    int op, fn, alu, sh, dst;
    logic s2, s1z, rw, mr, mw, br, j, jr;
    logic [31:0] imm;
    op = int'(i[31:26]); fn = int'(i[5:0]);
    alu = 0; sh = 0; dst = 0; imm = 0;
    {s2, s1z, rw, mr, mw, br, j, jr, il} = '0;
    if (op == 0) begin
      if (fn inside {'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2a}) begin
        alu = fn == 'h2a ? 7 : fn < 'h24 ? (fn < 'h22 ? 1 : 2) : fn - 'h24 + 3;
        rw = 1; dst = int'(i[15:11]);
      end else if (fn == 0 || fn == 2) begin
        alu = 8 + fn / 2; sh = int'(i[10:6]); rw = 1; dst = int'(i[15:11]);
      end else if (fn == 8) jr = 1;
      else il = 1;
    end else if (op inside {'h08, 'h09, 'h0a, 'h0c, 'h0d, 'h0e, 'h0f, 'h23}) begin
      s2 = 1; rw = 1; dst = int'(i[20:16]);
      if (op inside {'h0c, 'h0d, 'h0e}) begin
        alu = op - 'h09; imm = {16'h0, i[15:0]};
      end else if (op == 'h0f) begin
        alu = 1; s1z = 1; imm = {i[15:0], 16'h0};
      end else begin
        alu = op == 'h0a ? 7 : 1; imm = $signed(i[15:0]); mr = op == 'h23;
      end
    end else if (op == 'h2b) begin
      alu = 1; s2 = 1; mw = 1; imm = $signed(i[15:0]);
    end else if (op == 4 || op == 5) begin
      alu = op + 6; br = 1; imm = $signed(i[15:0]);
    end else if (op == 2 || op == 3) begin
      j = 1; if (op == 3) begin rw = 1; dst = 31; end
    end else il = 1;
    if (dst == 0) rw = 0;
    b = il ? '0 : {alu[3:0], sh[4:0], s2, imm, s1z, rw, dst[4:0], mr, mw, br, j, jr};
  endtask
  task automatic cyc(input logic v, input logic [31:0] ins, input logic fl, input logic ordy);
    logic [54:0] b;
    logic il, acc;
    bus.in_valid = v; bus.instr = ins; bus.flush = fl; bus.out_ready = ordy;
    #1;
    chk("in_ready", bus.in_ready, !exp_v || ordy);
    acc = v && (!exp_v || ordy) && !fl;
    ref_dec(ins, b, il);
    @(posedge clk);
    if (fl) exp_v = 0;
    else if (acc) begin exp_v = 1; exp_b = b; exp_il = exp_il | il; end
    else if (ordy) exp_v = 0;
    #1;
    chk("out_valid", bus.out_valid, exp_v);
    chk("illegal", bus.illegal, exp_il);
    if (exp_v) chk($sformatf("bundle[%08h]", ins), obs, exp_b);
  endtask
  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int ops[20] = '{0, 0, 0, 0, 2, 3, 4, 5, 8, 9, 'h0a, 'h0c, 'h0d, 'h0e, 'h0f, 'h23, 'h2b, 0, 'h23, 99};
    int fns[14] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2a, 0, 2, 8, 0, 99};
    int o, f;
    r = $urandom;
    o = ops[$urandom_range(0, 19)];
    if (o == 99) o = int'($urandom_range(0, 63));
    f = fns[$urandom_range(0, 13)];
    if (f == 99) f = int'($urandom_range(0, 63));
    r[31:26] = o[5:0];
    if (o == 0) r[5:0] = f[5:0];
    return r;
  endfunction
  initial begin
    rst = 1'b0;
    bus.in_valid = 0; bus.instr = 0; bus.flush = 0; bus.out_ready = 1;
    exp_v = 0; exp_il = 0; exp_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset payload", obs, 0);
    chk("reset illegal", bus.illegal, 0);
    rst = 1'b1;
    cyc(1, 32'h00221820, 0, 1);
    chk("add ALUOp", bus.ALUOp, 1);
    chk("add wr_dst", bus.wr_dst, 3);
    chk("add reg_write", bus.reg_write, 1);
    chk("add src2_imm", bus.src2_imm, 0);
    cyc(1, 32'h30858001, 0, 1);
    chk("andi imm", bus.imm_ext, 32'h00008001);
    cyc(1, 32'h20858001, 0, 1);
    chk("addi imm", bus.imm_ext, 32'hffff8001);
    cyc(1, 32'h00021100, 0, 1);
    repeat (3) cyc(1, 32'h00221820, 0, 0);
    chk("sll held ALUOp", bus.ALUOp, 8);
    chk("sll held shamt", bus.shamt, 4);
    cyc(0, 32'h0, 0, 1);
    cyc(1, 32'h10220008, 0, 1);
    chk("beq ALUOp", bus.ALUOp, 10);
    cyc(1, 32'h14220008, 0, 1);
    chk("bne ALUOp", bus.ALUOp, 11);
    chk("bne branch", bus.branch, 1);
    cyc(1, 32'h00021100, 0, 0);
    cyc(1, 32'h20858001, 1, 0);
    chk("flush out_valid", bus.out_valid, 0);
    cyc(1, 32'h00000000, 0, 1);
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    cyc(1, 32'hfc000000, 0, 1);
    chk("3F ALUOp", bus.ALUOp, 0);
    chk("3F illegal", bus.illegal, 1);
    cyc(1, 32'h00221820, 0, 0);
    cyc(1, 32'h20858001, 0, 0);
    chk("illegal sticky", bus.illegal, 1);
    #2 rst = 1'b0;
    #1;
    exp_v = 0; exp_il = 0;
    chk("midreset out_valid", bus.out_valid, 0);
    chk("midreset payload", obs, 0);
    chk("midreset illegal", bus.illegal, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    cyc(1, 32'h20858001, 0, 1);
    cyc(0, 32'h0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
